// File: rtl/extui_shared_pkg.sv
// Shared helpers for the time-multiplexed zero-extension datapath.
package extui_shared_pkg;

  // Ceiling log2, never below 1 so a single-channel tag still has one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/extui_shared_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually taken (adv=1).
module extui_shared_rr_arbiter
  import extui_shared_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int TAG_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              adv,
  output logic [NUM_CH-1:0] grant,
  output logic [TAG_W-1:0]  idx,
  output logic              found
);

  logic [TAG_W-1:0] ptr_q, ptr_d;

  // Two passes: channels at/after the pointer first, then the wrapped ones.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = TAG_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = TAG_W'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && adv) begin
      ptr_d = (int'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/extui_shared.sv
// NUM_CH elastic channels share one LATENCY-deep zero-extension pipeline; a tag
// rides with each token and steers the result back to its own output channel.
module extui_shared
  import extui_shared_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int INPUT_TYPE  = 32,
  parameter int OUTPUT_TYPE = 64,
  parameter int LATENCY     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*INPUT_TYPE-1:0]  ins,
  input  logic [NUM_CH-1:0]             ins_valid,
  output logic [NUM_CH-1:0]             ins_ready,
  output logic [NUM_CH*OUTPUT_TYPE-1:0] outs,
  output logic [NUM_CH-1:0]             outs_valid,
  input  logic [NUM_CH-1:0]             outs_ready
);

  localparam int TAG_W = clog2_min1(NUM_CH);
  localparam int LAST  = LATENCY - 1;

  logic                   vld_q [LATENCY];
  logic                   vld_d [LATENCY];
  logic [TAG_W-1:0]       tag_q [LATENCY];
  logic [TAG_W-1:0]       tag_d [LATENCY];
  logic [OUTPUT_TYPE-1:0] dat_q [LATENCY];
  logic [OUTPUT_TYPE-1:0] dat_d [LATENCY];

  logic [NUM_CH-1:0]     grant;
  logic [TAG_W-1:0]      win_idx;
  logic                  win_found;
  logic                  adv;
  logic                  fire;
  logic                  acc;
  logic [INPUT_TYPE-1:0] win_data;

  extui_shared_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .TAG_W  (TAG_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (ins_valid),
    .adv   (adv),
    .grant (grant),
    .idx   (win_idx),
    .found (win_found)
  );

  // Drain: head token is presented only on its tagged channel; data is broadcast.
  always_comb begin
    outs_valid = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (vld_q[LAST] && (int'(tag_q[LAST]) == j)) outs_valid[j] = 1'b1;
    end
  end

  assign fire      = |(outs_valid & outs_ready);
  assign adv       = !vld_q[LAST] || fire;
  assign ins_ready = grant & {NUM_CH{adv}};
  assign acc       = win_found && adv;
  assign outs      = {NUM_CH{dat_q[LAST]}};

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_data = win_data | ins[i*INPUT_TYPE +: INPUT_TYPE];
    end
  end

  // Stage 0 load (zero-extend) and lockstep shift; a stall freezes every stage.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i];
      tag_d[i] = tag_q[i];
      dat_d[i] = dat_q[i];
    end
    if (adv) begin
      vld_d[0] = acc;
      tag_d[0] = win_idx;
      dat_d[0] = {{(OUTPUT_TYPE-INPUT_TYPE){1'b0}}, win_data};
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) vld_q[i] <= vld_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      tag_q[i] <= tag_d[i];
      dat_q[i] <= dat_d[i];
    end
  end

endmodule
